// File: rtl/srl_sra_seq32.sv
// Multi-cycle logical/arithmetic right shifter: one log2 stage per clock.
// Define SHIFT_EARLY_EXIT_EN to finish as soon as no higher shift-amount bits remain.
module srl_sra_seq32 #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] shiftamt,
    input  logic               arith,
    output logic [WIDTH-1:0]   Out,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state_o
);

    // Handshake: an op is accepted on a rising edge where start=1 and ready=1.
    // Out is valid from the cycle done=1 until the next accepted op completes.

    localparam int CNT_W = $clog2(SHAMT_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHAMT_W - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   w_q, w_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   out_q, out_d;

    logic [WIDTH-1:0]   stage_res [SHAMT_W];
    logic [WIDTH-1:0]   stage_w;
    logic               stage_en;
    logic [WIDTH-1:0]   w_nxt;
    logic               last_stage;
    logic               early_exit;

    // Stage k shifts by 2^k, pulling in the latched fill bit from the top.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stage_res[k] = {{SH{fill_q}}, w_q[WIDTH-1:SH]};
    end

`ifdef SHIFT_EARLY_EXIT_EN
    assign early_exit = ((shamt_q >> (cnt_q + 1'b1)) == '0);
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        stage_w  = w_q;
        stage_en = 1'b0;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                stage_w  = stage_res[k];
                stage_en = shamt_q[k];
            end
        end
    end

    assign w_nxt      = stage_en ? stage_w : w_q;
    assign last_stage = (cnt_q == LAST_CNT) || early_exit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        shamt_d = shamt_q;
        fill_d  = fill_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_d     = A;
                    shamt_d = shiftamt;
                    fill_d  = arith & A[WIDTH-1];
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_d   = w_nxt;
                cnt_d = cnt_q + 1'b1;
                if (last_stage) begin
                    out_d   = w_nxt;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            shamt_q <= shamt_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
        end
    end

    assign Out         = out_q;
    assign ready       = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SHIFT);
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule
